// File: rtl/tinyrv_spi_mem.sv
// SPI mode-0 master serving tinyrv fetch/LSU requests as cmd+addr+data transactions.
// Define TINYRV_SPI_WRITE_EN to build the write path (cmd 0x02); otherwise every request reads.
module tinyrv_spi_mem #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned CS_IDLE    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [1:0]              req_nbytes,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    spi_sck,
  output logic                    spi_cs_n,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

  localparam int unsigned DW   = 8 * DATA_BYTES;
  localparam int unsigned HDR  = 8 + ADDR_W;
  localparam int unsigned FW   = HDR + DW;
  localparam int unsigned BW   = $clog2(FW);
  localparam int unsigned DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAPW = $clog2(CS_IDLE + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StDone} state_e;

  state_e          state_q;
  logic [GAPW-1:0] gap_q;
  logic [DIVW-1:0] div_q;
  logic [BW-1:0]   bit_q;
  logic [BW-1:0]   last_q;
  logic [FW-1:0]   tx_q;
  logic [DW-1:0]   rx_q;
  logic [6:0]      rx_byte_q;
  logic [DW-1:0]   rdata_q;
  logic            sck_q;
  logic            cs_n_q;
  logic            mosi_q;
  logic            rsp_valid_q;

  logic [7:0]    cmd;
  logic [DW-1:0] wdata_swapped;  // byte 0 in the top lane so it follows the address on the wire
  logic [1:0]    nbytes_clamped;
  logic [BW-1:0] last_bit;
  logic [1:0]    rx_idx;
  logic          rx_byte_done;
  logic          is_read;

  always_comb begin
    cmd           = 8'h03;
    wdata_swapped = '0;
`ifdef TINYRV_SPI_WRITE_EN
    if (req_we) begin
      cmd = 8'h02;
      for (int k = 0; k < int'(DATA_BYTES); k++) begin
        wdata_swapped[8*(int'(DATA_BYTES)-1-k) +: 8] = req_wdata[8*k +: 8];
      end
    end
`endif
    nbytes_clamped = (32'(req_nbytes) >= DATA_BYTES) ? 2'(DATA_BYTES - 1) : req_nbytes;
    last_bit       = BW'(HDR + 8 * (32'(nbytes_clamped) + 1) - 1);
    rx_idx         = 2'((bit_q - BW'(HDR)) >> 3);
    rx_byte_done   = (3'(bit_q - BW'(HDR)) == 3'd7);
  end

`ifdef TINYRV_SPI_WRITE_EN
  logic we_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
    end else if (req_valid && req_ready) begin
      we_q <= req_we;
    end
  end
  assign is_read = ~we_q;
`else
  logic unused_write;
  assign unused_write = ^{req_we, req_wdata};
  assign is_read      = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gap_q       <= GAPW'(CS_IDLE);
      div_q       <= '0;
      bit_q       <= '0;
      last_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rx_byte_q   <= '0;
      rdata_q     <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - 1'b1;
      unique case (state_q)
        StIdle: begin
          if (req_ready && req_valid) begin
            state_q <= StCmd;
            cs_n_q  <= 1'b0;
            mosi_q  <= cmd[7];
            tx_q    <= {cmd, req_addr, wdata_swapped};
            bit_q   <= '0;
            div_q   <= '0;
            last_q  <= last_bit;
            rx_q    <= '0;
          end
        end
        StCmd, StAddr, StData: begin
          if (div_q != DIVW'(CLK_DIV - 1)) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
              // miso sampled on the edge where sck rises
              if (state_q == StData) begin
                rx_byte_q <= {rx_byte_q[5:0], spi_miso};
                if (rx_byte_done) rx_q[8*rx_idx +: 8] <= {rx_byte_q, spi_miso};
              end
            end else begin
              sck_q <= 1'b0;
              if (bit_q == last_q) begin
                state_q <= StDone;
                mosi_q  <= 1'b0;
                gap_q   <= GAPW'(CS_IDLE);
              end else begin
                bit_q  <= bit_q + 1'b1;
                mosi_q <= tx_q[FW-2];
                tx_q   <= tx_q << 1;
                if (bit_q == BW'(7)) state_q <= StAddr;
                else if (bit_q == BW'(HDR - 1)) state_q <= StData;
              end
            end
          end
        end
        StDone: begin
          cs_n_q      <= 1'b1;
          rsp_valid_q <= 1'b1;
          if (is_read) rdata_q <= rx_q;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The response cycle never accepts, even when CS_IDLE is 1.
  assign req_ready = (state_q == StIdle) && (gap_q == '0) && !rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign spi_sck   = sck_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_tinyrv_spi_mem.sv
// Scoreboard bench for tinyrv_spi_mem: default instance A and a CLK_DIV=3 instance B,
// each with a mode-0 slave model that captures mosi and serves miso data bytes.
module tb_tinyrv_spi_mem;

  localparam int HDR     = 32;
  localparam int CS_IDLE = 2;
  localparam int DIV_A   = 1;
  localparam int DIV_B   = 3;

  typedef struct {
    logic [31:0] rdata;
    logic [63:0] mosi;
    int          chk;
    int          bits;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks   = 0;
  int failures = 0;
  exp_t sb[$];
  logic [31:0] last_rdata_a = '0;

  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [23:0] a_req_addr = '0;
  logic [1:0]  a_req_nbytes = '0;
  logic [31:0] a_req_wdata = '0;
  logic        a_req_ready, a_rsp_valid, a_sck, a_cs_n, a_mosi, a_miso;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [23:0] b_req_addr = '0;
  logic [1:0]  b_req_nbytes = '0;
  logic [31:0] b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_sck, b_cs_n, b_mosi, b_miso;
  logic [31:0] b_rsp_rdata;

  tinyrv_spi_mem u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_nbytes(a_req_nbytes),
    .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .spi_sck(a_sck), .spi_cs_n(a_cs_n), .spi_mosi(a_mosi), .spi_miso(a_miso)
  );

  tinyrv_spi_mem #(.CLK_DIV(DIV_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_nbytes(b_req_nbytes),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .spi_sck(b_sck), .spi_cs_n(b_cs_n), .spi_mosi(b_mosi), .spi_miso(b_miso)
  );

  // Slave model: data byte k (k-th ascending address) is bytes[8k+7:8k], sent MSB first.
  logic [31:0] a_miso_bytes = '0, b_miso_bytes = '0;
  logic [63:0] a_cap = '0, b_cap = '0;
  int a_edges = 0, b_edges = 0;

  function automatic logic miso_bit(input logic [31:0] bytes, input int idx);
    int d;
    d = idx - HDR;
    if (d < 0 || d >= 32) return 1'b0;
    return bytes[8 * (d / 8) + 7 - (d % 8)];
  endfunction

  function automatic int nbits(input int nb);
    return HDR + 8 * (nb + 1);
  endfunction

  function automatic int exp_lat(input int div, input int nb);
    return 2 * div * nbits(nb) + 1;
  endfunction

  always @(negedge a_cs_n) begin a_edges = 0; a_cap = '0; end
  always @(posedge a_sck) begin a_cap = {a_cap[62:0], a_mosi}; a_edges++; end
  assign a_miso = miso_bit(a_miso_bytes, a_edges);

  always @(negedge b_cs_n) begin b_edges = 0; b_cap = '0; end
  always @(posedge b_sck) begin b_cap = {b_cap[62:0], b_mosi}; b_edges++; end
  assign b_miso = miso_bit(b_miso_bytes, b_edges);

  // Drive a request and return at the handshake edge; req_valid is left high.
  task automatic issue(input bit sel, input logic we, input logic [23:0] addr,
                       input logic [1:0] nb, input logic [31:0] wd, output bit ok);
    int n = 0;
    @(negedge clk);
    if (sel) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_nbytes = nb;
      b_req_wdata = wd;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_nbytes = nb;
      a_req_wdata = wd;
    end
    while (!(sel ? b_req_ready : a_req_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = sel ? b_req_ready : a_req_ready;
    if (ok) @(posedge clk);
  endtask

  task automatic wait_rsp(input bit sel, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 2000);
  endtask

  task automatic test_reset();
    int n = 0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (a_cs_n !== 1'b1 || a_sck !== 1'b0 || a_mosi !== 1'b0) begin
      failures++;
      $display("FAIL reset_spi_pins got cs_n=%b sck=%b mosi=%b want 1 0 0", a_cs_n, a_sck, a_mosi);
    end
    checks++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rsp got valid=%b rdata=%h want 0 00000000", a_rsp_valid, a_rsp_rdata);
    end
    checks++;
    if (a_req_ready !== 1'b0 || b_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got ready=%b b_cs_n=%b want 0 1", a_req_ready, b_cs_n);
    end
    @(negedge clk) rst_n = 1'b1;
    while (a_req_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== CS_IDLE) begin
      failures++;
      $display("FAIL reset_ready_delay got %0d want %0d", n, CS_IDLE);
    end
  endtask

  task automatic test_word_read();
    bit ok;
    int lat;
    exp_t e;
    a_miso_bytes = 32'hDEADBEEF;
    sb.push_back('{rdata: 32'hDEADBEEF, mosi: 64'h03001234, chk: 32, bits: nbits(3),
                   lat: exp_lat(DIV_A, 3)});
    issue(1'b0, 1'b0, 24'h001234, 2'd3, 32'h0, ok);
    #1 a_req_valid = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL word_read_accept got no handshake want handshake"); end
    wait_rsp(1'b0, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      failures++; $display("FAIL word_read_latency got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (a_rsp_rdata !== e.rdata) begin
      failures++; $display("FAIL word_read_rdata got %h want %h", a_rsp_rdata, e.rdata);
    end
    checks++;
    if ((a_cap >> (e.bits - e.chk)) !== e.mosi) begin
      failures++;
      $display("FAIL word_read_mosi got %h want %h", a_cap >> (e.bits - e.chk), e.mosi);
    end
    checks++;
    if (a_edges !== e.bits || a_cs_n !== 1'b1 || a_sck !== 1'b0) begin
      failures++;
      $display("FAIL word_read_end got edges=%0d cs_n=%b sck=%b want %0d 1 0", a_edges, a_cs_n,
               a_sck, e.bits);
    end
    last_rdata_a = e.rdata;
  endtask

  task automatic test_byte_read_div3();
    bit ok;
    int lat;
    exp_t e;
    b_miso_bytes = 32'h5A5A5AA5;
    sb.push_back('{rdata: 32'h000000A5, mosi: 64'h03000100, chk: 32, bits: nbits(0),
                   lat: exp_lat(DIV_B, 0)});
    issue(1'b1, 1'b0, 24'h000100, 2'd0, 32'h0, ok);
    #1 b_req_valid = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL byte_read_accept got no handshake want handshake"); end
    wait_rsp(1'b1, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      failures++; $display("FAIL byte_read_latency got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (b_rsp_rdata !== e.rdata) begin
      failures++; $display("FAIL byte_read_rdata got %h want %h", b_rsp_rdata, e.rdata);
    end
    checks++;
    if ((b_cap >> (e.bits - e.chk)) !== e.mosi) begin
      failures++;
      $display("FAIL byte_read_mosi got %h want %h", b_cap >> (e.bits - e.chk), e.mosi);
    end
    checks++;
    if (b_edges !== e.bits) begin
      failures++; $display("FAIL byte_read_sck_edges got %0d want %0d", b_edges, e.bits);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    int n;
    exp_t e;
    a_miso_bytes = 32'h87654321;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{rdata: 32'h00004321, mosi: 64'h03000040, chk: 32, bits: nbits(1),
                     lat: exp_lat(DIV_A, 1)});
    end
    issue(1'b0, 1'b0, 24'h000040, 2'd1, 32'h0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_accept got no handshake want handshake"); end
    wait_rsp(1'b0, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || a_rsp_rdata !== e.rdata) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d rdata=%h want %0d %h", lat, a_rsp_rdata, e.lat, e.rdata);
    end
    checks++;
    if (a_req_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_ready_in_rsp got %b want 0", a_req_ready);
    end
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (a_cs_n !== 1'b1) break;
      n++;
    end
    a_req_valid = 1'b0;
    checks++;
    if (n !== CS_IDLE) begin
      failures++; $display("FAIL b2b_cs_gap got %0d want %0d", n, CS_IDLE);
    end
    wait_rsp(1'b0, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || a_rsp_rdata !== e.rdata) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d rdata=%h want %0d %h", lat, a_rsp_rdata, e.lat,
               e.rdata);
    end
    checks++;
    if ((a_cap >> (e.bits - e.chk)) !== e.mosi) begin
      failures++;
      $display("FAIL b2b_mosi got %h want %h", a_cap >> (e.bits - e.chk), e.mosi);
    end
    last_rdata_a = e.rdata;
  endtask

  task automatic test_write();
    bit ok;
    int lat;
    exp_t e;
`ifdef TINYRV_SPI_WRITE_EN
    sb.push_back('{rdata: last_rdata_a, mosi: 64'h020000104433, chk: 48, bits: nbits(1),
                   lat: exp_lat(DIV_A, 1)});
`else
    sb.push_back('{rdata: 32'h0000F00D, mosi: 64'h03000010, chk: 32, bits: nbits(1),
                   lat: exp_lat(DIV_A, 1)});
`endif
    a_miso_bytes = 32'hCAFEF00D;
    issue(1'b0, 1'b1, 24'h000010, 2'd1, 32'h11223344, ok);
    #1 a_req_valid = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL write_accept got no handshake want handshake"); end
    wait_rsp(1'b0, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      failures++; $display("FAIL write_latency got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (a_rsp_rdata !== e.rdata) begin
      failures++; $display("FAIL write_rdata got %h want %h", a_rsp_rdata, e.rdata);
    end
    checks++;
    if ((a_cap >> (e.bits - e.chk)) !== e.mosi) begin
      failures++;
      $display("FAIL write_mosi got %h want %h", a_cap >> (e.bits - e.chk), e.mosi);
    end
    last_rdata_a = e.rdata;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    int pulses = 0;
    a_miso_bytes = 32'h12345678;
    issue(1'b0, 1'b0, 24'h000200, 2'd3, 32'h0, ok);
    #1 a_req_valid = 1'b0;
    repeat (30) @(posedge clk);
    checks++;
    if (a_cs_n !== 1'b0) begin
      failures++; $display("FAIL reset_mid_busy got cs_n=%b want 0", a_cs_n);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (a_cs_n !== 1'b1 || a_sck !== 1'b0 || a_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abort got cs_n=%b sck=%b rsp_valid=%b want 1 0 0", a_cs_n, a_sck,
               a_rsp_valid);
    end
    @(negedge clk) rst_n = 1'b1;
    while (a_req_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== CS_IDLE) begin
      failures++; $display("FAIL reset_mid_ready_delay got %0d want %0d", n, CS_IDLE);
    end
    repeat (300) begin
      @(posedge clk);
      #1;
      if (a_rsp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || a_rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_no_rsp got pulses=%0d rdata=%h want 0 00000000", pulses,
               a_rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_read_div3();
    test_back_to_back();
    test_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
